// File: rtl/divisor_frc_pkg.sv
// divisor_frc_pkg: shared constants and helpers for the elevator clock divider.
package divisor_frc_pkg;

  // Board clock and the divide ratio that turns it into a 1 Hz tick.
  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int DIV_1HZ     = 50_000_000;

  // Clocks spent low in one output period (ceiling half of div). The high
  // phase gets the floor half, so odd ratios carry the extra clock while low.
  function automatic int low_cycles(input int div);
    return div - (div / 2);
  endfunction

endpackage : divisor_frc_pkg

// File: rtl/mod_n_counter.sv
// mod_n_counter: free-running modulo-N counter, 0..N-1, with a wrap flag.
// wrap is high while cnt == N-1, i.e. on the cycle whose next edge returns to 0.
module mod_n_counter
  import divisor_frc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == LAST);

  // Next count: wrap to zero after N-1, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (wrap) begin
      cnt_d = '0;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mod_n_counter

// File: rtl/divisor_frc_vm.sv
// divisor_frc_vm: divides clk by DIV into the square wave clk2.
// clk2 is low for the ceiling half of each period and high for the floor half.
// It is registered in parallel with the counter, from the counter's next value,
// so clk2 == (cnt >= LOW_CYCLES) holds on every cycle, including in reset.
// Optional build macro: DIVISOR_FRC_TICK_EN adds a one-cycle 'tick' output
// aligned with every clk2 rising transition (tick == (cnt == LOW_CYCLES)).
module divisor_frc_vm
  import divisor_frc_pkg::*;
#(
  parameter int DIV   = DIV_1HZ,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
`ifdef DIVISOR_FRC_TICK_EN
  output logic tick,
`endif
  output logic clk2
);

  localparam int LOW_CYCLES = low_cycles(DIV);
  localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW_CYCLES);

  // A ratio below 2 cannot produce both a low and a high phase.
  if (DIV < 2) begin : g_bad_div
    $error("divisor_frc_vm: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] cnt_next;
  logic             clk2_d;
  logic             clk2_q;

  mod_n_counter #(
    .N (DIV),
    .W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  assign clk2 = clk2_q;

  // Output level the counter's next value implies; both update on the same edge.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (wrap) begin
      cnt_next = '0;
    end
    clk2_d = (cnt_next >= LOW_C);
  end

  // clk2 register: forced low immediately on reset, so no partial pulse survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk2_q <= 1'b0;
    end else begin
      clk2_q <= clk2_d;
    end
  end

`ifdef DIVISOR_FRC_TICK_EN
  logic tick_d;
  logic tick_q;

  assign tick = tick_q;

  // Tick is high on exactly the cycle the counter sits at the low/high boundary.
  always_comb begin
    tick_d = (cnt_next == LOW_C);
  end

  // Tick register, cleared with the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end
`endif

endmodule : divisor_frc_vm

// File: tb/tb_divisor_frc_vm.sv
// tb_divisor_frc_vm: randomized reset/run sequences on four divide ratios
// (2, 4, 5, 7) driven from one clock and reset, against an arithmetic model:
// after n clock edges since reset release, cnt = n mod DIV and
// clk2 = (n mod DIV) >= DIV - DIV/2.
module tb_divisor_frc_vm;

  logic clk;
  logic rst;
  logic clk2_2, clk2_4, clk2_5, clk2_7;
`ifdef DIVISOR_FRC_TICK_EN
  logic tick_2, tick_4, tick_5, tick_7;
`endif

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;  // 50 MHz, rising edges at 10, 30, 50 ... ns

  // ---------------- DUTs ----------------
  divisor_frc_vm #(.DIV(2)) u_dut2 (
    .clk (clk), .rst (rst),
`ifdef DIVISOR_FRC_TICK_EN
    .tick (tick_2),
`endif
    .clk2 (clk2_2));
  divisor_frc_vm #(.DIV(4)) u_dut4 (
    .clk (clk), .rst (rst),
`ifdef DIVISOR_FRC_TICK_EN
    .tick (tick_4),
`endif
    .clk2 (clk2_4));
  divisor_frc_vm #(.DIV(5)) u_dut5 (
    .clk (clk), .rst (rst),
`ifdef DIVISOR_FRC_TICK_EN
    .tick (tick_5),
`endif
    .clk2 (clk2_5));
  divisor_frc_vm #(.DIV(7)) u_dut7 (
    .clk (clk), .rst (rst),
`ifdef DIVISOR_FRC_TICK_EN
    .tick (tick_7),
`endif
    .clk2 (clk2_7));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_cnt(input int div, input int n);
    return n % div;
  endfunction

  function automatic logic [31:0] model_clk2(input int div, input int n);
    return ((n % div) >= (div - div / 2)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] model_tick(input int div, input int n);
    return (n > 0 && (n % div) == (div - div / 2)) ? 32'd1 : 32'd0;
  endfunction

  // Compare every DUT against the model, n = edges since release (0 in reset).
  task automatic check_all(input string phase, input int n);
    check({phase, " d2 clk2"}, 32'(clk2_2), model_clk2(2, n));
    check({phase, " d4 clk2"}, 32'(clk2_4), model_clk2(4, n));
    check({phase, " d5 clk2"}, 32'(clk2_5), model_clk2(5, n));
    check({phase, " d7 clk2"}, 32'(clk2_7), model_clk2(7, n));
    check({phase, " d4 cnt"},  32'(u_dut4.cnt), model_cnt(4, n));
    check({phase, " d5 cnt"},  32'(u_dut5.cnt), model_cnt(5, n));
    check({phase, " d7 cnt"},  32'(u_dut7.cnt), model_cnt(7, n));
`ifdef DIVISOR_FRC_TICK_EN
    check({phase, " d2 tick"}, 32'(tick_2), model_tick(2, n));
    check({phase, " d4 tick"}, 32'(tick_4), model_tick(4, n));
    check({phase, " d5 tick"}, 32'(tick_5), model_tick(5, n));
    check({phase, " d7 tick"}, 32'(tick_7), model_tick(7, n));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Run 'cycles' edges after a release, sampling 1 ns after each rising edge.
  task automatic run_cycles(input int cycles, inout int n);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      n++;
      check_all("run", n);
    end
  endtask

  // Assert reset at a random point between edges, check it takes effect
  // without a clock edge, hold it a few cycles, then release at a falling edge.
  task automatic async_reset(inout int n);
    int hold;
    @(negedge clk);
    #($urandom_range(1, 8));
    rst = 1'b1;
    #1;
    n = 0;
    check_all("rst_async", n);
    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_all("rst_hold", n);
    end
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    checks = 0;
    errors = 0;
    n = 0;

    // Power-on reset held for 100 ns (five clock edges).
    rst = 1'b1;
    #1;
    check_all("por", n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all("por_hold", n);
    end
    @(negedge clk);
    rst = 1'b0;

    // Deterministic pass: several full periods of every ratio.
    run_cycles(3 * 4 * 5 * 7 / 10, n);

    // Reset while d4's clk2 is high: bring it to cnt=2 first.
    async_reset(n);
    run_cycles(2, n);
    check("mid d4 high before rst", 32'(clk2_4), 32'd1);
    async_reset(n);
    run_cycles(8, n);

    // Randomized run lengths and reset points.
    for (int it = 0; it < 25; it++) begin
      run_cycles($urandom_range(1, 40), n);
      async_reset(n);
    end
    run_cycles(20, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #5ms;
    errors++;
    $display("FAIL timeout: got no finish expected finish before 5 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_divisor_frc_vm
